systolic_skew_feeder: RTL and testbench
=======================================

// Module: systolic_skew_feeder
// PURPOSE
//   Input staging for the Accel8x8 array. Accepts one N-element activation vector per
//   cycle over a valid/ready handshake and drives the array's left edge. Lane i is
//   delayed by i cycles, which gives the diagonal wavefront that the row of mac_unit PEs
//   expects.
//   Frames each tile: it tracks the feed phase, flushes the skew pipeline after the last
//   vector, then pulses done.
// PARAMETERS
//   N       8   number of array rows / output lanes
//   DATA_W  8   activation element width (signed, two's complement)
//   CNT_W   16  width of the per-tile vector counter
// PORTS
//   clk        in   1         clock; all logic on rising edge
//   rst        in   1         synchronous, active-high reset
//   in_valid   in   1         in_data/in_last valid this cycle
//   in_ready   out  1         feeder can accept a vector this cycle
//   in_data    in   N*DATA_W  element i = in_data[i*DATA_W +: DATA_W]
//   in_last    in   1         accepted vector is the last of the tile
//   lane_out   out  N*DATA_W  skewed activation to array row i (same packing)
//   lane_valid out  N         lane i carries a real element (0 = inserted bubble)
//   busy       out  1         state != IDLE
//   done       out  1         one-cycle pulse: last element of tile on lane N-1
//   vec_count  out  CNT_W     vectors accepted in current/last tile
// BEHAVIOUR
// - One clock (clk). Reset (rst) is synchronous and active-high.
// - Reset, including mid-operation, clears everything on the next edge:
//   - all skew registers and lane_out to 0; lane_valid to 0
//   - state to IDLE; done to 0; vec_count to 0
//   - in_ready is 1 in the first cycle after reset.
// - Accept = in_valid && in_ready.
// - in_ready is combinational: in_ready = (state != FLUSH).
// - Skew pipeline:
//   - Lane i is a chain of i+1 registers. The chains shift on every cycle; there is no
//     stall, because the array cannot stall.
//   - Accept at edge E: element i is visible on lane_out[i] in cycle k+i, where k is the
//     cycle that follows E. lane_valid[i] is 1 in that same cycle.
//   - A cycle with no accept injects 0 data with valid 0 into every chain head. Bubbles
//     therefore add 0 to the PEs, which is harmless.
// - Data is passed bit-exact. No arithmetic, no width change.
// - FSM:
//   - IDLE:
//     - accept && !in_last -> FEED
//     - accept && in_last -> FLUSH (single-vector tile)
//     - vec_count is loaded with 1 on the accept.
//   - FEED:
//     - each accept increments vec_count; it saturates at 2^CNT_W-1, no wrap
//     - accept && in_last -> FLUSH
//     - cycles without an accept just insert bubbles and stay in FEED
//   - FLUSH:
//     - lasts exactly N-1 cycles, timed by the flush counter; in_ready = 0
//     - in_valid is ignored; no data is consumed and the counter does not move
//     - then -> IDLE
// - done:
//   - Registered. High for exactly one cycle: the first IDLE cycle after FLUSH.
//   - That cycle is k+N-1 relative to the last accept, i.e. the cycle in which lane N-1
//     holds the final element.
// - vec_count holds its value in IDLE until the next tile's first accept. It is read
//   while done is high.
// - N=1: the FLUSH phase has zero length; done pulses in cycle k.
// TESTING
// - Reset: assert rst 2 cycles with in_valid=1.
//   -> lane_out=0, lane_valid=0, done=0, busy=0, in_ready=1, vec_count=0.
// - Single vector: elements i -> i+1 (1..8), in_last=1.
//   -> lane i = i+1 only in cycle k+i; in_ready=0 for cycles k..k+6.
//   -> done=1 only in cycle k+7; vec_count=1.
// - Three back-to-back vectors, element i = 10v+i (v=0..2), last on v=2.
//   -> lane 3 shows 3, 13, 23 in cycles k+3..k+5.
//   -> done in cycle k+9; vec_count=3.
// - Bubble: vector A, one idle cycle, vector B (last).
//   -> each lane shows A, then 0 with lane_valid=0, then B.
//   -> done 1 cycle later than in the no-gap case.
// - Hold in_valid=1 with new data through FLUSH.
//   -> no extra accepts; vec_count unchanged; lanes show only bubbles after the tile.
// - Assert rst during FLUSH cycle k+3.
//   -> all lanes 0 next cycle, no done pulse, busy=0; a new tile then runs normally.

Source files
------------

// File: rtl/systolic_skew_feeder.sv
// Input staging for the systolic array: one activation vector is accepted per cycle,
// and lane i is delayed by i cycles. Each tile ends with a pipeline flush and a done pulse.
module systolic_skew_feeder #(
  parameter int N      = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] in_data,
  input  logic                in_last,
  output logic [N*DATA_W-1:0] lane_out,
  output logic [N-1:0]        lane_valid,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    vec_count
);

  typedef enum logic [1:0] {IDLE, FEED, FLUSH} state_t;

  // The flush counter runs 0..N-2, which covers the N-1 cycles of the drain phase.
  localparam int FC_W = (N > 2) ? $clog2(N - 1) : 1;
  localparam logic [FC_W-1:0] FLUSH_LAST = (N > 1) ? FC_W'(N - 2) : '0;

  state_t          state;
  logic [FC_W-1:0] flush_cnt;
  logic            accept;

  assign in_ready = (state != FLUSH);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      done      <= 1'b0;
      vec_count <= '0;
      flush_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            vec_count <= CNT_W'(1);
            if (in_last) begin
              // With a single row there is nothing to drain, so done follows at once.
              if (N == 1) begin
                done <= 1'b1;
              end else begin
                state     <= FLUSH;
                flush_cnt <= '0;
              end
            end else begin
              state <= FEED;
            end
          end
        end
        FEED: begin
          if (accept) begin
            if (vec_count != '1) vec_count <= vec_count + 1'b1;
            if (in_last) begin
              if (N == 1) begin
                state <= IDLE;
                done  <= 1'b1;
              end else begin
                state     <= FLUSH;
                flush_cnt <= '0;
              end
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == FLUSH_LAST) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Lane i is a free-running chain of i+1 registers; non-accept cycles inject zero bubbles.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_W-1:0] pipe  [0:i];
    logic [i:0]        vpipe;

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j <= i; j++) pipe[j] <= '0;
        vpipe <= '0;
      end else begin
        pipe[0]  <= accept ? in_data[i*DATA_W +: DATA_W] : '0;
        vpipe[0] <= accept;
        for (int j = 1; j <= i; j++) begin
          pipe[j]  <= pipe[j-1];
          vpipe[j] <= vpipe[j-1];
        end
      end
    end

    assign lane_out[i*DATA_W +: DATA_W] = pipe[i];
    assign lane_valid[i]                = vpipe[i];
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Testbench for systolic_skew_feeder: directed tiles plus random traffic, compared each
// cycle against a timeline model built from per-edge accept history.
module tb_systolic_skew_feeder;

  localparam int N      = 8;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;
  localparam int HIST   = 1024;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [N*DATA_W-1:0] in_data;
  logic                in_last;
  logic [N*DATA_W-1:0] lane_out;
  logic [N-1:0]        lane_valid;
  logic                busy;
  logic                done;
  logic [CNT_W-1:0]    vec_count;

  systolic_skew_feeder #(.N(N), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .lane_out(lane_out),
    .lane_valid(lane_valid), .busy(busy), .done(done), .vec_count(vec_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: what was accepted at each edge, plus the timing of the current tile.
  logic [N*DATA_W-1:0] hist_d [0:HIST-1];
  bit                  hist_v [0:HIST-1];
  int cyc        = 0;
  int last_rst   = 0;
  int last_edge  = -100;
  int done_cycle = -100;
  bit open       = 0;
  int count      = 0;

  function automatic bit expReady(int c);
    return !(c >= last_edge && c <= last_edge + N - 2);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic checkOutput();
    int src;
    bit ev;
    logic [DATA_W-1:0] ed;
    for (int i = 0; i < N; i++) begin
      src = cyc - i;
      ev  = (src > last_rst) && hist_v[src];
      ed  = ev ? hist_d[src][i*DATA_W +: DATA_W] : '0;
      check($sformatf("lane_out[%0d]", i), 64'(lane_out[i*DATA_W +: DATA_W]), 64'(ed));
      check($sformatf("lane_valid[%0d]", i), 64'(lane_valid[i]), 64'(ev));
    end
    check("done", 64'(done), 64'(cyc == done_cycle));
    check("busy", 64'(busy), 64'(open || !expReady(cyc)));
    check("vec_count", 64'(vec_count), 64'(count));
  endtask

  task automatic applyStimulus(input bit r, input bit v, input bit l,
                               input logic [N*DATA_W-1:0] d);
    bit acc;
    rst = r; in_valid = v; in_last = l; in_data = d;
    #1;
    if (!r) check("in_ready", 64'(in_ready), 64'(expReady(cyc)));
    acc = !r && v && expReady(cyc);
    @(posedge clk);
    cyc++;
    hist_v[cyc] = acc;
    hist_d[cyc] = d;
    if (r) begin
      last_rst = cyc; open = 0; count = 0; last_edge = -100; done_cycle = -100;
    end else if (acc) begin
      if (!open) begin
        open = 1; count = 1;
      end else if (count < (1 << CNT_W) - 1) begin
        count++;
      end
      if (l) begin
        open = 0; last_edge = cyc; done_cycle = cyc + N - 1;
      end
    end
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) applyStimulus(0, 0, 0, '0);
  endtask

  function automatic logic [N*DATA_W-1:0] mkVec(input int base);
    logic [N*DATA_W-1:0] x;
    for (int i = 0; i < N; i++) x[i*DATA_W +: DATA_W] = DATA_W'(base + i);
    return x;
  endfunction

  function automatic logic [N*DATA_W-1:0] rndVec();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    // Reset with in_valid held high
    applyStimulus(1, 1, 0, rndVec());
    applyStimulus(1, 1, 0, rndVec());

    // Single-vector tile, elements 1..8
    applyStimulus(0, 1, 1, mkVec(1));
    idle(10);

    // Three back-to-back vectors 10v+i
    applyStimulus(0, 1, 0, mkVec(0));
    applyStimulus(0, 1, 0, mkVec(10));
    applyStimulus(0, 1, 1, mkVec(20));
    idle(12);

    // Vector A, one bubble, vector B (last)
    applyStimulus(0, 1, 0, rndVec());
    idle(1);
    applyStimulus(0, 1, 1, rndVec());
    idle(12);

    // in_valid held with fresh data through the flush
    applyStimulus(0, 1, 0, rndVec());
    applyStimulus(0, 1, 1, rndVec());
    for (int j = 0; j < N - 1; j++) applyStimulus(0, 1, $urandom_range(0, 1), rndVec());
    idle(10);

    // Reset in flush cycle k+3, then a normal tile
    applyStimulus(0, 1, 0, rndVec());
    applyStimulus(0, 1, 1, rndVec());
    idle(3);
    applyStimulus(1, 1, 0, rndVec());
    applyStimulus(0, 1, 0, rndVec());
    applyStimulus(0, 1, 1, rndVec());
    idle(12);

    // Random traffic
    for (int j = 0; j < 300; j++)
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 4) == 0), rndVec());
    idle(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
